// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and LO/HI write-enable constants for the
// multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_MULT  = 4'h1,
    OP_MULTU = 4'h2,
    OP_DIV   = 4'h3,
    OP_DIVU  = 4'h4,
    OP_MTHI  = 4'h5,
    OP_MTLO  = 4'h6,
    OP_MADD  = 4'h7,
    OP_MADDU = 4'h8,
    OP_MSUB  = 4'h9,
    OP_MSUBU = 4'hA
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_WB   = 2'd3
  } state_e;

  localparam logic [1:0] WEN_NONE = 2'b00;
  localparam logic [1:0] WEN_LO   = 2'b01;
  localparam logic [1:0] WEN_HI   = 2'b10;
  localparam logic [1:0] WEN_BOTH = 2'b11;

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned magnitude datapath: shift-add multiply or
// restoring divide on the {hi,lo} accumulator pair. Purely combinational.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum_s;
  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;

  // MUL: lo holds the multiplier, consumed LSB first while the product shifts in.
  // DIV: lo holds the dividend, consumed MSB first while quotient bits shift in.
  always_comb begin
    sum_s     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    shifted_s = {hi_i, lo_i[XLEN-1]};
    diff_s    = shifted_s - {1'b0, opnd_i};
    if (is_div) begin
      if (diff_s[XLEN]) begin
        hi_o = shifted_s[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end else begin
        hi_o = diff_s[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end
    end else begin
      hi_o = sum_s[XLEN:1];
      lo_o = {sum_s[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MUL/DIV sequencer owning all LO/HI writes. Define MULDIV_MADD_EN
// to accept MADD/MADDU/MSUB/MSUBU (accumulate into {rHI,rLO} during WB).
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cancel,
  input  logic [XLEN-1:0] rLO,
  input  logic [XLEN-1:0] rHI,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] wLO,
  output logic [XLEN-1:0] wHI,
  output logic [1:0]      wen
);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d, a_q, a_d;
  logic [XLEN-1:0] wlo_q, wlo_d, whi_q, whi_d;
  logic            neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, divz_q, divz_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [1:0]      wen_q, wen_d;
`ifdef MULDIV_MADD_EN
  logic            madd_q, madd_d, msub_q, msub_d;
`endif

  logic [XLEN-1:0]   step_hi_s, step_lo_s, abs_a_s, abs_b_s, quo_s, rem_s;
  logic [2*XLEN-1:0] prod_s;
  logic              sgn_s, is_mul_s, is_div_s, step_div_s;

  assign step_div_s = (state_q == S_DIV);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (step_div_s),
    .hi_i   (acc_hi_q),
    .lo_i   (acc_lo_q),
    .opnd_i (opnd_q),
    .hi_o   (step_hi_s),
    .lo_o   (step_lo_s)
  );

  // Request decode and operand magnitudes for signed ops.
  always_comb begin
    sgn_s    = op_is_signed(op);
    abs_a_s  = (sgn_s && a[XLEN-1]) ? -a : a;
    abs_b_s  = (sgn_s && b[XLEN-1]) ? -b : b;
    is_div_s = (op == OP_DIV) || (op == OP_DIVU);
    is_mul_s = (op == OP_MULT) || (op == OP_MULTU)
`ifdef MULDIV_MADD_EN
               || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU)
`endif
               ;
  end

  // Sign fix-up of the final iteration; divide by zero overrides the raw result.
  always_comb begin
    prod_s = neg_lo_q ? -{step_hi_s, step_lo_s} : {step_hi_s, step_lo_s};
    quo_s  = divz_q ? {XLEN{1'b1}} : (neg_lo_q ? -step_lo_s : step_lo_s);
    rem_s  = divz_q ? a_q : (neg_hi_q ? -step_hi_s : step_hi_s);
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    divz_d   = divz_q;
    wlo_d    = {XLEN{1'b0}};
    whi_d    = {XLEN{1'b0}};
    wen_d    = WEN_NONE;
`ifdef MULDIV_MADD_EN
    madd_d   = madd_q;
    msub_d   = msub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          if (is_mul_s) begin
            state_d  = S_MUL;
            cnt_d    = CNT_W'(XLEN-1);
            acc_hi_d = {XLEN{1'b0}};
            acc_lo_d = abs_b_s;
            opnd_d   = abs_a_s;
            neg_lo_d = sgn_s & (a[XLEN-1] ^ b[XLEN-1]);
            neg_hi_d = 1'b0;
            divz_d   = 1'b0;
`ifdef MULDIV_MADD_EN
            madd_d   = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
            msub_d   = (op == OP_MSUB) || (op == OP_MSUBU);
`endif
          end else if (is_div_s) begin
            state_d  = S_DIV;
            cnt_d    = CNT_W'(XLEN-1);
            acc_hi_d = {XLEN{1'b0}};
            acc_lo_d = abs_a_s;
            opnd_d   = abs_b_s;
            a_d      = a;
            neg_lo_d = sgn_s & (a[XLEN-1] ^ b[XLEN-1]);
            neg_hi_d = sgn_s & a[XLEN-1];
            divz_d   = (b == {XLEN{1'b0}});
`ifdef MULDIV_MADD_EN
            madd_d   = 1'b0;
            msub_d   = 1'b0;
`endif
          end else if (op == OP_MTHI) begin
            state_d = S_WB;
            whi_d   = a;
            wen_d   = WEN_HI;
          end else if (op == OP_MTLO) begin
            state_d = S_WB;
            wlo_d   = a;
            wen_d   = WEN_LO;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_hi_d = step_hi_s;
          acc_lo_d = step_lo_s;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = S_WB;
            wen_d   = WEN_BOTH;
            if (state_q == S_MUL) begin
              {whi_d, wlo_d} = prod_s;
            end else begin
              whi_d = rem_s;
              wlo_d = quo_s;
            end
          end else begin
            state_d = state_q;
          end
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_WB);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_hi_q <= {XLEN{1'b0}};
      acc_lo_q <= {XLEN{1'b0}};
      opnd_q   <= {XLEN{1'b0}};
      a_q      <= {XLEN{1'b0}};
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      divz_q   <= 1'b0;
      wlo_q    <= {XLEN{1'b0}};
      whi_q    <= {XLEN{1'b0}};
      wen_q    <= WEN_NONE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_MADD_EN
      madd_q   <= 1'b0;
      msub_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      divz_q   <= divz_d;
      wlo_q    <= wlo_d;
      whi_q    <= whi_d;
      wen_q    <= wen_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MULDIV_MADD_EN
      madd_q   <= madd_d;
      msub_q   <= msub_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign wen  = wen_q;

`ifdef MULDIV_MADD_EN
  logic [2*XLEN-1:0] madd_sum_s;

  // Accumulate ops combine the held product with the LO/HI value current in WB.
  always_comb begin
    if (madd_q && (state_q == S_WB)) begin
      madd_sum_s = msub_q ? ({rHI, rLO} - {whi_q, wlo_q}) : ({rHI, rLO} + {whi_q, wlo_q});
    end else begin
      madd_sum_s = {whi_q, wlo_q};
    end
  end

  assign {wHI, wLO} = madd_sum_s;
`else
  logic unused_s;
  assign unused_s = ^{rHI, rLO};
  assign wHI = whi_q;
  assign wLO = wlo_q;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: table-driven vectors through a scoreboard
// queue, plus hand-written cancel / busy / reset / undefined-op sequences.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk, rst_n, start, cancel;
  logic [3:0]  op;
  logic [31:0] a, b, rLO, rHI, wLO, wHI;
  logic        busy, done;
  logic [1:0]  wen;

  int tests_run    = 0;
  int tests_failed = 0;
  int wen_seen     = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [1:0]  wen;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    logic [1:0]  wen;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .rLO(rLO), .rHI(rHI), .busy(busy), .done(done),
    .wLO(wLO), .wHI(wHI), .wen(wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (wen !== 2'b00) wen_seen <= wen_seen + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] hi, input logic [31:0] lo,
                               input logic [1:0] w, input int lat);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.hi = hi; v.lo = lo; v.wen = w; v.lat = lat;
    return v;
  endfunction

  // Reference model used for the random vectors.
  function automatic vec_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic        sg;
    logic [63:0] ux, uy, p;
    longint      sx, sy, q, r;
    sg = (o == OP_MULT) || (o == OP_DIV);
    ux = sg ? {{32{x[31]}}, x} : {32'h0, x};
    uy = sg ? {{32{y[31]}}, y} : {32'h0, y};
    if ((o == OP_MULT) || (o == OP_MULTU)) begin
      p = ux * uy;
      return mkv(o, x, y, p[63:32], p[31:0], 2'b11, 32);
    end else if (y == 32'h0) begin
      return mkv(o, x, y, x, 32'hFFFF_FFFF, 2'b11, 32);
    end else begin
      sx = ux; sy = uy;
      q = sx / sy; r = sx % sy;
      return mkv(o, x, y, r[31:0], q[31:0], 2'b11, 32);
    end
  endfunction

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   n;
    e.hi = v.hi; e.lo = v.lo; e.wen = v.wen; e.lat = v.lat;
    sb.push_back(e);
    issue(v.op, v.a, v.b);
    if (v.lat > 0) check($sformatf("v%0d_busy", idx), 64'(busy), 64'(1));
    n = 0;
    while (done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    if (done !== 1'b1) begin
      check($sformatf("v%0d_done_timeout", idx), 64'(done), 64'(1));
    end else begin
      check($sformatf("v%0d_latency", idx), 64'(n), 64'(e.lat));
      check($sformatf("v%0d_wen", idx), 64'(wen), 64'(e.wen));
      if (e.wen[1]) check($sformatf("v%0d_wHI", idx), 64'(wHI), 64'(e.hi));
      if (e.wen[0]) check($sformatf("v%0d_wLO", idx), 64'(wLO), 64'(e.lo));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", idx), 64'(done), 64'(0));
      check($sformatf("v%0d_wen_after", idx), 64'(wen), 64'(0));
      check($sformatf("v%0d_busy_after", idx), 64'(busy), 64'(0));
    end
  endtask

  initial begin
    int base;
    logic [3:0] rop;
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 4'h0;
    a = 32'h0; b = 32'h0; rLO = 32'h0; rHI = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_wen", 64'(wen), 64'(0));
    check("reset_wLO", 64'(wLO), 64'(0));
    check("reset_wHI", 64'(wHI), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    vecs.push_back(mkv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2'b11, 32));
    vecs.push_back(mkv(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2'b11, 32));
    vecs.push_back(mkv(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2'b11, 32));
    vecs.push_back(mkv(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 2'b11, 32));
    vecs.push_back(mkv(OP_DIVU,  32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF, 2'b11, 32));
    vecs.push_back(mkv(OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 2'b11, 32));
    vecs.push_back(mkv(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 2'b11, 32));
    vecs.push_back(mkv(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 2'b11, 32));
    vecs.push_back(mkv(OP_DIVU,  32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 2'b11, 32));
    vecs.push_back(mkv(OP_MTLO,  32'h0000_1234, 32'h0,         32'h0,         32'h0000_1234, 2'b01, 0));
    vecs.push_back(mkv(OP_MTHI,  32'h0000_0055, 32'h0,         32'h0000_0055, 32'h0,         2'b10, 0));
    for (int i = 0; i < 6; i++) begin
      rop = 4'(OP_MULT + (i % 4));
      vecs.push_back(model(rop, $urandom, (i > 3) ? 32'($urandom_range(1, 300)) : $urandom));
    end
`ifdef MULDIV_MADD_EN
    rHI = 32'h0; rLO = 32'hFFFF_FFFF;
    vecs.push_back(mkv(OP_MADDU, 32'h1, 32'h1, 32'h0000_0001, 32'h0000_0000, 2'b11, 32));
`endif
    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Cancel mid-multiply: back to IDLE without a write, next start accepted.
    base = wen_seen;
    issue(OP_MULT, 32'd3, 32'd5);
    repeat (8) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_idle", 64'(busy), 64'(0));
    check("cancel_no_wen", 64'(wen_seen), 64'(base));
    start = 1'b1; op = OP_MTLO; a = 32'h77;
    @(negedge clk);
    start = 1'b0;
    check("post_cancel_done", 64'(done), 64'(1));
    check("post_cancel_wen", 64'(wen), 64'(2'b01));
    check("post_cancel_wLO", 64'(wLO), 64'(32'h77));
    @(negedge clk);

    // Cancel together with start in IDLE drops the request.
    start = 1'b1; cancel = 1'b1; op = OP_MULTU; a = 32'h9; b = 32'h9;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_start_busy", 64'(busy), 64'(0));

    // Undefined op codes are ignored.
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      op = (i == 0) ? OP_NOP : ((i == 1) ? 4'hF : 4'hB);
      @(negedge clk);
      start = 1'b0;
      check($sformatf("undef_op%0d_busy", i), 64'(busy), 64'(0));
      check($sformatf("undef_op%0d_wen", i), 64'(wen), 64'(0));
    end
`ifndef MULDIV_MADD_EN
    start = 1'b1; op = OP_MADD; a = 32'h1; b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    check("madd_disabled_busy", 64'(busy), 64'(0));
`endif

    // Start while busy is ignored; reset mid-op aborts with no write.
    base = wen_seen;
    issue(OP_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'h99;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored_busy", 64'(busy), 64'(1));
    check("busy_start_ignored_wen", 64'(wen), 64'(0));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_reset_busy", 64'(busy), 64'(0));
    check("midop_reset_wen", 64'(wen), 64'(0));
    check("midop_reset_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midop_reset_no_write", 64'(wen_seen), 64'(base));
    check("midop_reset_idle", 64'(busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
